// File: rtl/vector_vector_alu_mc.sv
// Vector-vector ALU: per-chain firmware op between an N-lane input vector and a
// VRF operand, with an optional write-back into the VRF and read-after-write forwarding.
module vector_vector_alu_mc #(
  parameter int unsigned N                  = 8,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned MAX_CHAINS         = 4,
  parameter int unsigned VRF_DEPTH          = 8,
  parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0,
  parameter bit          SATURATE           = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic                          eof_in,
  input  logic                          bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
  output logic                          valid_out,
  output logic                          eof_out,
  output logic                          bof_out
);

  localparam int unsigned CW = $clog2(MAX_CHAINS);
  localparam int unsigned AW = $clog2(VRF_DEPTH);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned VW = N * DATA_WIDTH;
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [7:0] {
    OP_PASS = 8'd0, OP_ADD = 8'd1, OP_MUL = 8'd2, OP_SUB = 8'd3,
    OP_MAX  = 8'd4, OP_MIN = 8'd5, OP_OPND = 8'd6
  } op_e;

  typedef enum logic [7:0] {
    COND_NONE = 8'd0, COND_LAST = 8'd1, COND_NOTLAST = 8'd2,
    COND_FIRST = 8'd3, COND_NOTFIRST = 8'd4
  } cond_e;

  typedef enum logic [2:0] {
    F_OP, F_ADDR_RD, F_COND, F_CACHE, F_CACHE_ADDR
  } field_e;

  // Firmware: address fields keep only the bits that index the VRF; cache keeps its nonzero flag.
  logic [7:0]    fw_op_q    [MAX_CHAINS];
  logic [7:0]    fw_op_d    [MAX_CHAINS];
  logic [AW-1:0] fw_rd_q    [MAX_CHAINS];
  logic [AW-1:0] fw_rd_d    [MAX_CHAINS];
  logic [7:0]    fw_cond_q  [MAX_CHAINS];
  logic [7:0]    fw_cond_d  [MAX_CHAINS];
  logic          fw_cache_q [MAX_CHAINS];
  logic          fw_cache_d [MAX_CHAINS];
  logic [AW-1:0] fw_wr_q    [MAX_CHAINS];
  logic [AW-1:0] fw_wr_d    [MAX_CHAINS];
  field_e        cfg_field_q, cfg_field_d;
  logic [CW-1:0] cfg_chain_q, cfg_chain_d;

  logic [VW-1:0] vrf_q [VRF_DEPTH];
  logic [VW-1:0] vrf_d [VRF_DEPTH];

  logic          s1_valid_q, s1_valid_d;
  logic          s1_eof_q, s1_eof_d;
  logic          s1_bof_q, s1_bof_d;
  logic [CW-1:0] s1_chain_q, s1_chain_d;
  logic [VW-1:0] s1_vec_q, s1_vec_d;
  logic [VW-1:0] s1_opnd_q, s1_opnd_d;
  logic [7:0]    s1_op_q, s1_op_d;
  logic [7:0]    s1_cond_q, s1_cond_d;
  logic          s1_cache_q, s1_cache_d;
  logic [AW-1:0] s1_wr_q, s1_wr_d;

  logic [VW-1:0] vector_out_q, vector_out_d;
  logic [CW-1:0] chain_out_q, chain_out_d;
  logic          valid_out_q, valid_out_d;
  logic          eof_out_q, eof_out_d;
  logic          bof_out_q, bof_out_d;

  logic [AW-1:0] rd_addr;
  logic          cond_ok;
  logic          vrf_we;
  logic [VW-1:0] result;

  function automatic logic [DW-1:0] clamp(input logic [DW:0] ext);
    if (SATURATE && (ext[DW] != ext[DW-1])) return ext[DW] ? SMIN : SMAX;
    return ext[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] lane_op(input logic [7:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = a;
    case (op)
      OP_ADD:  r = clamp({a[DW-1], a} + {b[DW-1], b});
      OP_MUL:  r = a * b;
      OP_SUB:  r = clamp({a[DW-1], a} - {b[DW-1], b});
      OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
      OP_OPND: r = b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Config bus: field index is kept as a (chain, field) pair, equivalent to k = 5*chain + field.
  always_comb begin
    fw_op_d     = fw_op_q;
    fw_rd_d     = fw_rd_q;
    fw_cond_d   = fw_cond_q;
    fw_cache_d  = fw_cache_q;
    fw_wr_d     = fw_wr_q;
    cfg_field_d = cfg_field_q;
    cfg_chain_d = cfg_chain_q;
    if (!tracing) begin
      if (configId != PERSONAL_CONFIG_ID) begin
        cfg_field_d = F_OP;
        cfg_chain_d = '0;
      end else begin
        case (cfg_field_q)
          F_OP:         fw_op_d[cfg_chain_q]    = configData;
          F_ADDR_RD:    fw_rd_d[cfg_chain_q]    = configData[AW-1:0];
          F_COND:       fw_cond_d[cfg_chain_q]  = configData;
          F_CACHE:      fw_cache_d[cfg_chain_q] = |configData;
          F_CACHE_ADDR: fw_wr_d[cfg_chain_q]    = configData[AW-1:0];
          default:      ;
        endcase
        if (cfg_field_q == F_CACHE_ADDR) begin
          cfg_field_d = F_OP;
          cfg_chain_d = (cfg_chain_q == CW'(MAX_CHAINS - 1)) ? '0 : cfg_chain_q + CW'(1);
        end else begin
          cfg_field_d = field_e'(cfg_field_q + 3'd1);
        end
      end
    end
  end

  // S2: conditional op on the registered S1 vector.
  always_comb begin
    case (s1_cond_q)
      COND_NONE:     cond_ok = 1'b1;
      COND_LAST:     cond_ok = s1_eof_q;
      COND_NOTLAST:  cond_ok = !s1_eof_q;
      COND_FIRST:    cond_ok = s1_bof_q;
      COND_NOTFIRST: cond_ok = !s1_bof_q;
      default:       cond_ok = 1'b0;
    endcase
    result = s1_vec_q;
    if (cond_ok) begin
      for (int unsigned i = 0; i < N; i++) begin
        result[i*DW +: DW] = lane_op(s1_op_q, s1_vec_q[i*DW +: DW], s1_opnd_q[i*DW +: DW]);
      end
    end
  end

  assign vrf_we  = s1_valid_q && s1_cache_q && tracing;
  assign rd_addr = fw_rd_q[chainId_in];

  always_comb begin
    for (int unsigned e = 0; e < VRF_DEPTH; e++) vrf_d[e] = vrf_q[e];
    if (vrf_we) vrf_d[s1_wr_q] = result;
  end

  // S1 capture; the operand bypasses the VRF when S2 writes the same entry on this edge.
  always_comb begin
    s1_valid_d = valid_in;
    s1_eof_d   = eof_in;
    s1_bof_d   = bof_in;
    s1_chain_d = chainId_in;
    s1_vec_d   = vector_in;
    s1_op_d    = fw_op_q[chainId_in];
    s1_cond_d  = fw_cond_q[chainId_in];
    s1_cache_d = fw_cache_q[chainId_in];
    s1_wr_d    = fw_wr_q[chainId_in];
    s1_opnd_d  = (vrf_we && (s1_wr_q == rd_addr)) ? result : vrf_q[rd_addr];
  end

  always_comb begin
    vector_out_d = vector_out_q;
    chain_out_d  = chain_out_q;
    eof_out_d    = eof_out_q;
    bof_out_d    = bof_out_q;
    valid_out_d  = 1'b0;
    if (tracing) begin
      vector_out_d = result;
      chain_out_d  = s1_chain_q;
      eof_out_d    = s1_eof_q;
      bof_out_d    = s1_bof_q;
      valid_out_d  = s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < MAX_CHAINS; c++) begin
        fw_op_q[c]    <= '0;
        fw_rd_q[c]    <= '0;
        fw_cond_q[c]  <= '0;
        fw_cache_q[c] <= 1'b0;
        fw_wr_q[c]    <= '0;
      end
      for (int unsigned e = 0; e < VRF_DEPTH; e++) vrf_q[e] <= '0;
      cfg_field_q  <= F_OP;
      cfg_chain_q  <= '0;
      s1_valid_q   <= 1'b0;
      s1_eof_q     <= 1'b0;
      s1_bof_q     <= 1'b0;
      s1_chain_q   <= '0;
      s1_vec_q     <= '0;
      s1_opnd_q    <= '0;
      s1_op_q      <= '0;
      s1_cond_q    <= '0;
      s1_cache_q   <= 1'b0;
      s1_wr_q      <= '0;
      vector_out_q <= '0;
      chain_out_q  <= '0;
      valid_out_q  <= 1'b0;
      eof_out_q    <= 1'b0;
      bof_out_q    <= 1'b0;
    end else begin
      fw_op_q      <= fw_op_d;
      fw_rd_q      <= fw_rd_d;
      fw_cond_q    <= fw_cond_d;
      fw_cache_q   <= fw_cache_d;
      fw_wr_q      <= fw_wr_d;
      vrf_q        <= vrf_d;
      cfg_field_q  <= cfg_field_d;
      cfg_chain_q  <= cfg_chain_d;
      s1_valid_q   <= s1_valid_d;
      s1_eof_q     <= s1_eof_d;
      s1_bof_q     <= s1_bof_d;
      s1_chain_q   <= s1_chain_d;
      s1_vec_q     <= s1_vec_d;
      s1_opnd_q    <= s1_opnd_d;
      s1_op_q      <= s1_op_d;
      s1_cond_q    <= s1_cond_d;
      s1_cache_q   <= s1_cache_d;
      s1_wr_q      <= s1_wr_d;
      vector_out_q <= vector_out_d;
      chain_out_q  <= chain_out_d;
      valid_out_q  <= valid_out_d;
      eof_out_q    <= eof_out_d;
      bof_out_q    <= bof_out_d;
    end
  end

  assign vector_out  = vector_out_q;
  assign chainId_out = chain_out_q;
  assign valid_out   = valid_out_q;
  assign eof_out     = eof_out_q;
  assign bof_out     = bof_out_q;

endmodule

// File: tb/tb_vector_vector_alu_mc.sv
// Directed bench for vector_vector_alu_mc: a default 8x32 wrapping instance (config id 0)
// and a 4x8 saturating instance (config id 1) sharing the control inputs.
module tb_vector_vector_alu_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tracing;
  logic         valid_in;
  logic         eof_in;
  logic         bof_in;
  logic [1:0]   chainId_in;
  logic [7:0]   configId;
  logic [7:0]   configData;
  logic [255:0] vector_in;
  logic [255:0] vector_out;
  logic [1:0]   chainId_out;
  logic         valid_out, eof_out, bof_out;
  logic [31:0]  vector_in_s;
  logic [31:0]  vector_out_s;
  logic [1:0]   chainId_out_s;
  logic         valid_out_s, eof_out_s, bof_out_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] fw_bytes [20];

  always #5 clk = ~clk;

  vector_vector_alu_mc #(
    .N(8), .DATA_WIDTH(32), .MAX_CHAINS(4), .VRF_DEPTH(8),
    .PERSONAL_CONFIG_ID(8'd0), .SATURATE(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .chainId_out(chainId_out), .valid_out(valid_out),
    .eof_out(eof_out), .bof_out(bof_out)
  );

  vector_vector_alu_mc #(
    .N(4), .DATA_WIDTH(8), .MAX_CHAINS(4), .VRF_DEPTH(8),
    .PERSONAL_CONFIG_ID(8'd1), .SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in_s),
    .vector_out(vector_out_s), .chainId_out(chainId_out_s), .valid_out(valid_out_s),
    .eof_out(eof_out_s), .bof_out(bof_out_s)
  );

  function automatic logic [255:0] rep32(input logic [31:0] v);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [255:0] alt32(input logic [31:0] ev, input logic [31:0] od);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = (i % 2 == 0) ? ev : od;
    return r;
  endfunction

  function automatic logic [31:0] rep8(input logic [7:0] v);
    return {v, v, v, v};
  endfunction

  task automatic drive(input logic v, input logic [1:0] ch, input logic e, input logic b,
                       input logic [255:0] vec, input logic [31:0] vs);
    tracing = 1'b1; valid_in = v; chainId_in = ch; eof_in = e; bof_in = b;
    vector_in = vec; vector_in_s = vs;
  endtask

  task automatic program_fw(input logic [7:0] id);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tracing = 1'b0; valid_in = 1'b0; configId = id; configData = fw_bytes[i];
    end
    @(negedge clk);
    configId = 8'hFF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; eof_in = 1'b0; bof_in = 1'b0;
    chainId_in = '0; configId = 8'hFF; configData = '0; vector_in = '0; vector_in_s = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_checks++; if (vector_out !== '0) begin n_fail++; $display("FAIL reset_vec: got %h expected 0", vector_out); end
    n_checks++; if ({chainId_out, eof_out, bof_out} !== 4'b0) begin n_fail++; $display("FAIL reset_side: got %b expected 0000", {chainId_out, eof_out, bof_out}); end
    n_checks++; if ({valid_out_s, vector_out_s} !== 33'b0) begin n_fail++; $display("FAIL reset_sat: got %h expected 0", {valid_out_s, vector_out_s}); end
    rst_n = 1'b1;
  endtask

  task automatic test_accumulate();
    logic [255:0] exp;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        exp = rep32(32'((t - 1) * 5));
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL accum_valid[%0d]: got %b expected 1", t, valid_out); end
        n_checks++; if (vector_out !== exp) begin n_fail++; $display("FAIL accum_vec[%0d]: got %h expected %h", t, vector_out, exp); end
        n_checks++; if (chainId_out !== 2'd0) begin n_fail++; $display("FAIL accum_chain[%0d]: got %0d expected 0", t, chainId_out); end
      end
      if (t < 4) drive(1'b1, 2'd0, 1'b0, 1'b0, rep32(32'd5), '0);
      else       drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    end
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL accum_idle: got %b expected 0", valid_out); end
  endtask

  task automatic test_max();
    logic [1:0]   ch  [3];
    logic [255:0] vin [3];
    logic [255:0] exp [3];
    ch  = '{2'd2, 2'd1, 2'd1};
    vin = '{rep32(32'hFFFF_FFFD), alt32(32'hFFFF_FFF9, 32'd4), alt32(32'd4, 32'hFFFF_FFF9)};
    exp = '{rep32(32'hFFFF_FFFD), alt32(32'hFFFF_FFFD, 32'd4), alt32(32'd4, 32'hFFFF_FFFD)};
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        n_checks++; if (vector_out !== exp[t-2] || valid_out !== 1'b1) begin n_fail++; $display("FAIL max_vec[%0d]: got %b/%h expected 1/%h", t - 2, valid_out, vector_out, exp[t-2]); end
      end
      if (t < 3) drive(1'b1, ch[t], 1'b0, 1'b0, vin[t], '0);
      else       drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_cond_last();
    logic [31:0] val [4];
    logic [31:0] exp [4];
    logic        e   [4];
    logic        b   [4];
    val = '{32'd10, 32'd0, 32'd30, 32'd1};
    exp = '{32'd10, 32'd0, 32'd30, 32'd31};
    e   = '{1'b0, 1'b0, 1'b1, 1'b1};
    b   = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        n_checks++; if (vector_out !== rep32(exp[t-2])) begin n_fail++; $display("FAIL cond_vec[%0d]: got %h expected %h", t - 2, vector_out, rep32(exp[t-2])); end
        n_checks++; if ({valid_out, eof_out, bof_out, chainId_out} !== {1'b1, e[t-2], b[t-2], 2'd3}) begin n_fail++; $display("FAIL cond_side[%0d]: got %b expected %b", t - 2, {valid_out, eof_out, bof_out, chainId_out}, {1'b1, e[t-2], b[t-2], 2'd3}); end
      end
      if (t < 4) drive(1'b1, 2'd3, e[t], b[t], rep32(val[t]), '0);
      else       drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] ch  [5];
    logic [7:0] val [5];
    logic [7:0] exp [5];
    ch  = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
    val = '{8'd100, 8'd100, 8'h9C, 8'd20, 8'd10};
    exp = '{8'd100, 8'h7F, 8'h80, 8'd120, 8'hA6};
    fw_bytes = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0,  8'd3, 8'd0, 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd0, 8'd1, 8'd0,  8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    program_fw(8'd1);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        n_checks++; if (vector_out_s !== rep8(exp[t-2]) || valid_out_s !== 1'b1) begin n_fail++; $display("FAIL sat_vec[%0d]: got %b/%h expected 1/%h", t - 2, valid_out_s, vector_out_s, rep8(exp[t-2])); end
      end
      if (t < 5) drive(1'b1, ch[t], 1'b0, 1'b0, '0, rep8(val[t]));
      else       drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk); drive(1'b1, 2'd1, 1'b0, 1'b0, rep32(32'hFFFF_FFF9), '0);
    @(negedge clk); drive(1'b1, 2'd1, 1'b0, 1'b0, rep32(32'hFFFF_FFF9), '0);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({valid_out, vector_out} !== 257'b0) begin n_fail++; $display("FAIL rst_async: got %b/%h expected 0/0", valid_out, vector_out); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 1'b0, rep32(32'hFFFF_FFF9), '0);
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %b expected 0", valid_out); end
    drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b1 || vector_out !== rep32(32'hFFFF_FFF9)) begin n_fail++; $display("FAIL rst_fw_pass: got %b/%h expected 1/%h", valid_out, vector_out, rep32(32'hFFFF_FFF9)); end
  endtask

  task automatic test_config_restart();
    @(negedge clk); tracing = 1'b0; valid_in = 1'b0; configId = 8'd0; configData = 8'd1;
    @(negedge clk); configData = 8'd2;
    @(negedge clk); configId = 8'hFF;
    foreach (fw_bytes[i]) fw_bytes[i] = 8'd0;
    fw_bytes[0] = 8'd6; fw_bytes[1] = 8'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); configId = 8'd0; configData = fw_bytes[i];
    end
    @(negedge clk); configId = 8'hFF;
    @(negedge clk); drive(1'b1, 2'd0, 1'b0, 1'b0, rep32(32'd9), '0);
    @(negedge clk); drive(1'b0, 2'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b1 || vector_out !== '0) begin n_fail++; $display("FAIL cfg_restart_opnd: got %b/%h expected 1/0", valid_out, vector_out); end
  endtask

  task automatic test_tracing_drop();
    // config bytes presented while tracing must not alter chain 0 (op 6)
    @(negedge clk); drive(1'b1, 2'd0, 1'b0, 1'b0, rep32(32'd9), '0);  configId = 8'd0; configData = 8'd1;
    @(negedge clk); drive(1'b1, 2'd3, 1'b0, 1'b0, rep32(32'd11), '0);
    @(negedge clk); drive(1'b1, 2'd3, 1'b0, 1'b0, rep32(32'd12), '0);
    n_checks++; if (valid_out !== 1'b1 || vector_out !== '0) begin n_fail++; $display("FAIL trace_cfg_ignored: got %b/%h expected 1/0", valid_out, vector_out); end
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b1 || vector_out !== rep32(32'd11)) begin n_fail++; $display("FAIL trace_pre_drop: got %b/%h expected 1/%h", valid_out, vector_out, rep32(32'd11)); end
    configId = 8'hFF;
    drive(1'b1, 2'd3, 1'b0, 1'b0, rep32(32'd13), '0);
    tracing = 1'b0;
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL trace_drop_valid: got %b expected 0", valid_out); end
    n_checks++; if (vector_out !== rep32(32'd11)) begin n_fail++; $display("FAIL trace_drop_hold: got %h expected %h", vector_out, rep32(32'd11)); end
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    fw_bytes = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2,  8'd4, 8'd3, 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd0, 8'd1, 8'd3,  8'd1, 8'd5, 8'd1, 8'd1, 8'd5};
    program_fw(8'd0);
    test_accumulate();
    test_max();
    test_cond_last();
    test_saturate();
    test_reset_inflight();
    test_config_restart();
    test_tracing_drop();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_vector_alu_mc.md
Name: vector_vector_alu_mc

Overview:
- Next-generation vector-vector ALU for the tracing pipeline. Sits between the vector-scalar stage and the downstream reducer/filter stages.
- Applies a per-chain firmware op between each incoming N-lane vector and an operand read from an internal vector register file (VRF). Can cache the result back into the VRF.
- Changes from the previous generation:
  - parametrised VRF depth;
  - signed min/max and optional saturating add/sub;
  - runtime firmware programming over the config bus;
  - deterministic asynchronous reset;
  - explicit read-after-write forwarding.

Parameters:
- N, 8, vector lanes.
- DATA_WIDTH, 32, bits per lane, interpreted as two's complement for max/min/saturation.
- MAX_CHAINS, 4, number of firmware chains; must be at least 2.
- VRF_DEPTH, 8, number of VRF entries; must be a power of two and at least 2.
- PERSONAL_CONFIG_ID, 0, configId value that selects this block.
- SATURATE, 0, when 1 add/sub clamp to signed min/max; when 0 they wrap.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- tracing  in  1  1 = process vectors, 0 = idle/config.
- valid_in  in  1  input vector valid.
- eof_in  in  1  last vector of frame.
- bof_in  in  1  first vector of frame.
- chainId_in  in  $clog2(MAX_CHAINS)  selects firmware chain.
- configId  in  8  config bus target id.
- configData  in  8  config bus byte.
- vector_in  in  N x DATA_WIDTH  input lanes.
- vector_out  out  N x DATA_WIDTH  result lanes.
- chainId_out  out  $clog2(MAX_CHAINS)  delayed chainId.
- valid_out  out  1  result valid.
- eof_out  out  1  delayed eof.
- bof_out  out  1  delayed bof.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - During rst_n=0, every output, pipeline register, VRF entry, firmware field and the config counter is 0.
  - Reset mid-frame discards in-flight vectors; valid_out is 0 in the first cycle after release.
- Firmware: per chain c there are five 8-bit fields:
  - op[c]: 0 pass, 1 add, 2 mul (low DATA_WIDTH bits), 3 sub (vector-operand), 4 signed max, 5 signed min, 6 operand, 7..255 pass.
  - addr_rd[c]: VRF read address; low $clog2(VRF_DEPTH) bits are used.
  - cond[c]: 0 none, 1 last, 2 notlast, 3 first, 4 notfirst; 5..255 are never valid.
  - cache[c]: nonzero enables the VRF write.
  - cache_addr[c]: VRF write address; low bits are used.
- Config write:
  - Accepted only when tracing=0 and configId==PERSONAL_CONFIG_ID.
  - One configData byte is taken per cycle into field index k.
  - Field order is chain 0 {op, addr_rd, cond, cache, cache_addr}, then chain 1, and so on.
  - k increments per accepted byte and wraps from 5*MAX_CHAINS-1 to 0.
  - k resets to 0 in any cycle where configId != PERSONAL_CONFIG_ID.
  - Config traffic while tracing=1 is ignored, and k is held.
- Pipeline, S1 (edge after valid_in):
  - Registers vector, chainId, eof, bof and valid, plus the op/cond/cache/cache_addr fields of chainId_in.
  - Registers operand = VRF[addr_rd[chainId_in]].
  - Forwarding: if S2 performs a VRF write on this same edge to that address, operand takes the S2 write data instead.
- Pipeline, S2 (combinational, registered at the next edge):
  - cond_ok is evaluated from cond, eof and bof.
  - result = cond_ok ? op(vector, operand) : vector, computed lane-wise.
  - At the edge, if tracing=1:
    - vector_out <= result;
    - valid_out, eof_out, bof_out and chainId_out <= the S1 values.
  - If tracing=0: valid_out <= 0; the other outputs hold.
  - VRF write of result to cache_addr occurs iff S1 valid, cache != 0 and tracing=1.
- Latency: exactly 2 cycles from valid_in to valid_out. Throughput: one vector per cycle, with no back-pressure.
- Arithmetic:
  - With SATURATE=1, add/sub overflow clamps to 2^(DW-1)-1 or -2^(DW-1), per lane.
  - mul always truncates.
- Simultaneous events:
  - A config write and a vector in the same cycle cannot occur for this block, since config requires tracing=0.
  - A VRF write and a read of the same address at the same edge resolve via forwarding, so back-to-back accumulation is exact.

Test Plan:
- Reset then program chain 0 = {op 1, addr_rd 2, cond 0, cache 1, cache_addr 2}. Drive 4 back-to-back vectors of all lanes = 5 with tracing=1 → valid_out 2 cycles later with lanes 5, 10, 15, 20. This exercises forwarding every cycle.
- Chain 1 with op 4 (max) and a VRF entry holding -3 in all lanes; input lanes alternating -7/4 → output lanes -3/4.
- SATURATE=1, DATA_WIDTH=8, op 1; input 100 with operand 100 → 127. Op 3 with input -100 and operand 100 → -128.
- cond 1 (last), op 1: frame of 3 vectors with eof only on the third → first two pass through unmodified; the third is summed. cache writes only the third result.
- Assert rst_n low for 1 cycle while vectors are in flight → valid_out=0 next cycle; all firmware reads back as pass (op 0 behaviour); VRF reads 0.
- Drive config bytes with configId mismatching mid-stream → counter restarts; subsequent bytes land at chain 0 op. Toggle tracing=0 mid-stream → valid_out drops within 1 cycle.
